// File: rtl/uart_rx_unit.sv
// uart_rx_unit: UART receive path.
// A 16x-oversampling tick generator runs at the selected baud rate. A 2-flop
// synchroniser brings rx_serial into the clock domain. A frame FSM samples
// each bit at mid-bit, LSB first, checks the optional parity bit and the stop
// bit, and then reports the frame with a one-clock data_valid pulse.

module uart_rx_unit #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           baud_rate,
    input  logic [1:0]           parity_type,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_error,
    output logic                 stop_error,
    output logic                 rx_active
);

    // Tick divisors: round(CLK_FREQ / (baud * OVERSAMPLE)), in integer arithmetic.
    localparam int DIV_2400  = (CLK_FREQ + 2400  * OVERSAMPLE / 2) / (2400  * OVERSAMPLE);
    localparam int DIV_4800  = (CLK_FREQ + 4800  * OVERSAMPLE / 2) / (4800  * OVERSAMPLE);
    localparam int DIV_9600  = (CLK_FREQ + 9600  * OVERSAMPLE / 2) / (9600  * OVERSAMPLE);
    localparam int DIV_19200 = (CLK_FREQ + 19200 * OVERSAMPLE / 2) / (19200 * OVERSAMPLE);

    // The slowest rate has the largest divisor, so it sets the counter width.
    localparam int CNT_W = $clog2(DIV_2400 + 1);
    localparam int BIT_W = $clog2(DATA_BITS);

    // Sample points inside a bit, counted in ticks from the bit's start.
    localparam logic [3:0] S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     tick_cnt;
    logic [CNT_W-1:0]     div_m1;
    logic [1:0]           baud_q;
    logic                 tick;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 start_detect;
    logic [3:0]           s_cnt;
    logic [BIT_W-1:0]     b_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic [1:0]           par_mode;
    logic                 par_bit;
    logic                 par_en;
    logic                 par_exp;

    // Select the terminal count of the tick counter for the current baud rate.
    always_comb begin
        // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
        div_m1 = CNT_W'(DIV_2400 - 1);
        unique case (baud_rate)
            2'b00:   div_m1 = CNT_W'(DIV_2400 - 1);
            2'b01:   div_m1 = CNT_W'(DIV_4800 - 1);
            2'b10:   div_m1 = CNT_W'(DIV_9600 - 1);
            default: div_m1 = CNT_W'(DIV_19200 - 1);
        endcase
    end

    assign tick         = (tick_cnt == div_m1);
    assign start_detect = (state == IDLE) && rx_prev && !rx_s;

    // Parity modes 01 (odd) and 10 (even) are enabled; 00 and 11 mean no parity bit.
    assign par_en  = (par_mode == 2'b01) || (par_mode == 2'b10);
    assign par_exp = (par_mode == 2'b01) ? ~^shift_reg : ^shift_reg;

    // Oversampling tick generator; realigned on start detect and on any baud change.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all registers keep every flop sampling pre-edge values.
            tick_cnt <= '0;
            baud_q   <= 2'b00;
        end else begin
            baud_q <= baud_rate;
            if ((baud_rate != baud_q) || start_detect || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
        end
    end

    // Two-flop synchroniser plus a one-clock history of rx_s for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_serial;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Frame FSM: start validation, data shift, parity and stop checks, registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            s_cnt        <= 4'd0;
            b_idx        <= '0;
            shift_reg    <= '0;
            par_mode     <= 2'b00;
            par_bit      <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            rx_active    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    rx_active <= 1'b0;
                    if (start_detect) begin
                        state     <= START;
                        s_cnt     <= 4'd0;
                        par_mode  <= parity_type;
                        rx_active <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt == S_MID) begin
                            s_cnt <= 4'd0;
                            if (!rx_s) begin
                                state <= DATA;
                                b_idx <= '0;
                            end else begin
                                // Line back high at mid start bit: a glitch, not a frame.
                                state     <= IDLE;
                                rx_active <= 1'b0;
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt            <= 4'd0;
                            shift_reg[b_idx] <= rx_s;
                            if (b_idx == BIT_W'(DATA_BITS - 1)) begin
                                state <= par_en ? PARITY : STOP;
                            end else begin
                                b_idx <= b_idx + BIT_W'(1);
                            end
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt   <= 4'd0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt == S_LAST) begin
                            s_cnt        <= 4'd0;
                            data_out     <= shift_reg;
                            parity_error <= par_en && (par_bit != par_exp);
                            stop_error   <= !rx_s;
                            data_valid   <= 1'b1;
                            rx_active    <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            s_cnt <= s_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// tb_uart_rx_unit: self-checking bench for uart_rx_unit.
// A line driver builds frames from data/parity/stop rules and pushes the
// expected report into a scoreboard queue; a monitor pops and compares on
// every data_valid. A reduced CLK_FREQ keeps bit times short.

module tb_uart_rx_unit;

    localparam int CLK_FREQ_TB = 500_000;
    localparam int DATA_BITS   = 8;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       serr;
    } exp_t;

    logic                 clock;
    logic                 reset;
    logic [1:0]           baud_rate;
    logic [1:0]           parity_type;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_error;
    logic                 stop_error;
    logic                 rx_active;

    int   total;
    int   bad;
    int   n_valid;
    exp_t sb[$];
    exp_t mon_e;

    uart_rx_unit #(
        .CLK_FREQ  (CLK_FREQ_TB),
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .baud_rate   (baud_rate),
        .parity_type (parity_type),
        .rx_serial   (rx_serial),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .parity_error(parity_error),
        .stop_error  (stop_error),
        .rx_active   (rx_active)
    );

    // 100 MHz simulation clock (the DUT only sees CLK_FREQ_TB as a divisor parameter).
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Clocks per tick: nearest integer to CLK_FREQ / (baud * 16).
    function automatic int div_for(input logic [1:0] br);
        int baud;
        case (br)
            2'b00:   baud = 2400;
            2'b01:   baud = 4800;
            2'b10:   baud = 9600;
            default: baud = 19200;
        endcase
        return $rtoi(real'(CLK_FREQ_TB) / (real'(baud) * 16.0) + 0.5);
    endfunction

    function automatic int bit_clks(input logic [1:0] br);
        return 16 * div_for(br);
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic idle_bits(input logic [1:0] br, input int n);
        rx_serial = 1'b1;
        wait_clks(n * bit_clks(br));
    endtask

    // Drive one frame; optionally register the report the receiver must produce.
    task automatic send_frame(input logic [7:0] data, input logic [1:0] br, input logic [1:0] pt,
                              input bit flip_par, input bit stop_val, input bit expect_it);
        int   bc;
        bit   pen;
        bit   pbit;
        int   ones;
        exp_t e;
        bc   = bit_clks(br);
        pen  = (pt == 2'b01) || (pt == 2'b10);
        ones = $countones(data);
        // Even parity bit makes the total count of ones even; odd makes it odd.
        pbit = (pt == 2'b10) ? (ones % 2 == 1) : (ones % 2 == 0);
        pbit = pbit ^ flip_par;
        if (expect_it) begin
            e.data = data;
            e.perr = pen && flip_par;
            e.serr = !stop_val;
            sb.push_back(e);
        end
        baud_rate   = br;
        parity_type = pt;
        rx_serial   = 1'b0;
        wait_clks(bc);
        for (int i = 0; i < 8; i++) begin
            rx_serial = data[i];
            wait_clks(bc);
        end
        if (pen) begin
            rx_serial = pbit;
            wait_clks(bc);
        end
        rx_serial = stop_val;
        wait_clks(bc);
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 5000) begin
            wait_clks(1);
            k++;
        end
        check(name, sb.size(), 0);
    endtask

    // Monitor: every data_valid pulse is matched against the oldest expectation.
    always @(negedge clock) begin
        if (!reset && data_valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_valid: got pulse data_out=%0h expected no pulse", data_out);
            end else begin
                mon_e = sb.pop_front();
                check("data_out", data_out, mon_e.data);
                check("parity_error", parity_error, mon_e.perr);
                check("stop_error", stop_error, mon_e.serr);
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  v0;
        bit  seen;
        bit  last_stop;
        int  bc;
        logic [1:0] br;
        logic [1:0] pt;
        logic [7:0] d;
        bit  flip;
        bit  stp;

        total = 0;
        bad = 0;
        n_valid = 0;
        reset = 1'b1;
        rx_serial = 1'b1;
        baud_rate = 2'b11;
        parity_type = 2'b00;
        wait_clks(5);

        // Reset state.
        check("rst data_out", data_out, 0);
        check("rst data_valid", data_valid, 0);
        check("rst parity_error", parity_error, 0);
        check("rst stop_error", stop_error, 0);
        check("rst rx_active", rx_active, 0);
        reset = 1'b0;

        // 8N1 @19200, 0xA5.
        idle_bits(2'b11, 2);
        v0 = n_valid;
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b1, 1'b1);
        idle_bits(2'b11, 1);
        drain("drain 8N1");
        check("valids 8N1", n_valid - v0, 1);
        check("rx_active idle", rx_active, 0);

        // 8E1 @9600, 0x07 then with the parity bit flipped.
        v0 = n_valid;
        idle_bits(2'b10, 1);
        send_frame(8'h07, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1);
        idle_bits(2'b10, 1);
        send_frame(8'h07, 2'b10, 2'b10, 1'b1, 1'b1, 1'b1);
        idle_bits(2'b10, 1);
        drain("drain 8E1");
        check("valids 8E1", n_valid - v0, 2);

        // 8N1 @2400, 0x3C with stop bit low, then a two-frame break.
        v0 = n_valid;
        idle_bits(2'b00, 1);
        send_frame(8'h3C, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        rx_serial = 1'b0;
        wait_clks(20 * bit_clks(2'b00));
        drain("drain stop_err");
        idle_bits(2'b00, 2);
        check("valids break", n_valid - v0, 1);

        // Low glitch of 3/16 bit @19200.
        v0 = n_valid;
        baud_rate = 2'b11;
        idle_bits(2'b11, 1);
        seen = 1'b0;
        rx_serial = 1'b0;
        for (int i = 0; i < 3 * div_for(2'b11); i++) begin
            wait_clks(1);
            seen |= rx_active;
        end
        rx_serial = 1'b1;
        for (int i = 0; i < bit_clks(2'b11); i++) begin
            wait_clks(1);
            seen |= rx_active;
        end
        check("glitch rx_active seen", seen, 1);
        check("glitch rx_active end", rx_active, 0);
        idle_bits(2'b11, 2);
        check("valids glitch", n_valid - v0, 0);

        // Back-to-back 8O1 @4800 with no idle bits.
        v0 = n_valid;
        idle_bits(2'b01, 1);
        send_frame(8'h00, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        send_frame(8'hFF, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        send_frame(8'h55, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        idle_bits(2'b01, 1);
        drain("drain b2b");
        check("valids b2b", n_valid - v0, 3);

        // Reset 4 bits into a frame, released one frame later; then 0x81.
        v0 = n_valid;
        bc = bit_clks(2'b10);
        idle_bits(2'b10, 1);
        fork
            send_frame(8'h5A, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0);
            begin
                wait_clks(4 * bc);
                reset = 1'b1;
                wait_clks(2);
                check("midrst data_out", data_out, 0);
                check("midrst rx_active", rx_active, 0);
                check("midrst stop_error", stop_error, 0);
                check("midrst parity_error", parity_error, 0);
                wait_clks(10 * bc - 2);
                reset = 1'b0;
            end
        join
        wait_clks(2);
        check("postrst data_valid", data_valid, 0);
        check("postrst data_out", data_out, 0);
        check("valids aborted", n_valid - v0, 0);
        idle_bits(2'b10, 1);
        send_frame(8'h81, 2'b10, 2'b00, 1'b0, 1'b1, 1'b1);
        idle_bits(2'b10, 1);
        drain("drain after reset");
        check("valids after reset", n_valid - v0, 1);

        // Randomised frames: mixed rates, parity modes, occasional bad parity/stop.
        v0 = n_valid;
        last_stop = 1'b1;
        for (int n = 0; n < 12; n++) begin
            br   = 2'($urandom_range(1, 3));
            pt   = 2'($urandom_range(0, 3));
            d    = 8'($urandom);
            flip = ($urandom_range(0, 5) == 0);
            stp  = ($urandom_range(0, 5) != 0);
            if (last_stop) begin
                idle_bits(br, $urandom_range(0, 2));
            end else begin
                idle_bits(br, $urandom_range(1, 2));
            end
            send_frame(d, br, pt, flip, stp, 1'b1);
            last_stop = stp;
        end
        idle_bits(2'b01, 1);
        drain("drain random");
        check("valids random", n_valid - v0, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
